// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32x32 multiply / 32/32 divide unit with MIPS HI/LO results.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request a new operation (only looked at while idle)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b    multiplicand/dividend, multiplier/divisor
//   cancel  abort the operation in flight
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse when hi/lo have just been updated
//   hi, lo  product[63:32]/[31:0], or remainder/quotient
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold the last result
// CALC   | 32 radix-2 iterations on operand magnitudes
// FIX    | sign correction, hi/lo written on exit
// DONE   | done pulse, returns to IDLE
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic        op_div;
  logic        neg_res;
  logic        neg_rem;
  logic        b_zero;
  logic [31:0] a_raw;
  logic [31:0] mag_b;
  logic [63:0] acc;     // multiply: {partial product, multiplier}; divide: acc[31:0] is dividend/quotient
  logic [31:0] rem;
  logic        accept;
  logic        signed_op;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;

  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [63:0] prod_fix;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign accept    = (state == S_IDLE) && start && !cancel;
  assign signed_op = ~op[0];
  // Magnitude of 8000_0000 is 8000_0000, still exact as an unsigned 32-bit value.
  assign mag_a_in  = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign mag_b_in  = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !cancel) state_nxt = S_CALC;
      S_CALC: begin
        if (cancel)              state_nxt = S_IDLE;
        else if (count == 5'd31) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = cancel ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    mul_nxt = {mul_sum, acc[31:1]};
  end

  // Restoring division: a divisor of zero always "fits", giving an all-ones quotient.
  always_comb begin
    div_shift = {rem, acc[31]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (!div_diff[32]) begin
      rem_nxt = div_diff[31:0];
      quo_nxt = {acc[30:0], 1'b1};
    end else begin
      rem_nxt = div_shift[31:0];
      quo_nxt = {acc[30:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    if (!op_div) begin
      hi_res = prod_fix[63:32];
      lo_res = prod_fix[31:0];
    end else if (b_zero) begin
      hi_res = a_raw;
      lo_res = 32'hFFFF_FFFF;
    end else begin
      hi_res = neg_rem ? (~rem + 32'd1) : rem;
      lo_res = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 5'd0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= 32'd0;
      mag_b   <= 32'd0;
      acc     <= 64'd0;
      rem     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      if (accept) begin
        count   <= 5'd0;
        op_div  <= op[1];
        neg_res <= signed_op && (a[31] ^ b[31]);
        neg_rem <= (op == 2'b10) && a[31];
        b_zero  <= (b == 32'd0);
        a_raw   <= a;
        mag_b   <= mag_b_in;
        acc     <= {32'd0, mag_a_in};
        rem     <= 32'd0;
      end else if (state == S_CALC) begin
        count <= count + 5'd1;
        if (op_div) begin
          rem       <= rem_nxt;
          acc[31:0] <= quo_nxt;
        end else begin
          acc <= mul_nxt;
        end
      end
      if (state == S_FIX && !cancel) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: MIPS HI/LO results from ordinary integer arithmetic, returned as {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, q, r;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full operation: accepted at edge N, done sampled high just after edge N+33
  // (i.e. visible at edge N+34), hi/lo unchanged until then; inputs scrambled while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] expv);
    int dpos;
    int dcnt;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    dpos = -1;
    dcnt = 0;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 32) check({tag, " hilo_hold"}, {hi, lo}, {exp_hi, exp_lo});
      if (done) begin
        dcnt++;
        if (dpos < 0) dpos = k;
      end
    end
    check({tag, " done_pos"}, 64'(dpos), 64'd33);
    check({tag, " done_cnt"}, 64'(dcnt), 64'd1);
    check({tag, " result"}, {hi, lo}, expv);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    exp_hi = expv[63:32];
    exp_lo = expv[31:0];
  endtask

  initial begin
    int dcnt;
    int acc_cnt;
    int acc_pos[$];
    logic prev_busy;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;

    // start together with cancel in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_idle", 64'(busy), 64'd0);

    run_op("mult_neg2x3",   2'b00, 32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_0",      2'b11, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF);
    run_op("div_m7_0",      2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);
    run_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

    // cancel mid-divide with a second start asserted while busy
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      end
    end
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("cancel_quiet", 64'(dcnt), 64'd0);
    check("cancel_hilo", {hi, lo}, {exp_hi, exp_lo});

    // reset mid-operation
    @(negedge clk);
    op = 2'b00; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("rst_mid_no_done", 64'(dcnt), 64'd0);
    run_op("after_rst_divu", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

    // random operations against the model
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h0000_FFFF;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // back-to-back with start held high: accepts every 35 edges
    @(negedge clk);
    op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    prev_busy = busy;
    dcnt = 0;
    acc_cnt = 0;
    for (int e = 0; e <= 104; e++) begin
      @(posedge clk); #1;
      if (!prev_busy && busy) begin
        acc_cnt++;
        acc_pos.push_back(e);
      end
      if (done) dcnt++;
      prev_busy = busy;
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepts", 64'(acc_cnt), 64'd3);
    if (acc_pos.size() == 3) begin
      check("b2b_pos1", 64'(acc_pos[1] - acc_pos[0]), 64'd35);
      check("b2b_pos2", 64'(acc_pos[2] - acc_pos[1]), 64'd35);
    end
    check("b2b_dones", 64'(dcnt), 64'd3);
    check("b2b_result", {hi, lo}, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
